sd_spi_arbiter: RTL
===================

// Module: sd_spi_arbiter
// PURPOSE
//  Sequences and shares the single SD-card SPI port between the init engine, the sector-write
//  engine (sd_write) and the sector-read engine (sd_read). Latches user read/write requests,
//  grants round-robin, issues one start pulse and sector address per grant, and watches the engine's busy.
//  Muxes the engine's sd_cs/sd_mosi onto the pins. Flags stalled engines with a timeout.
// PARAMETERS
//  BUSY_WAIT   8         max cycles from start pulse to engine busy rising, else timeout
//  TIMEOUT     24'd2000000  max cycles engine busy may stay high, else timeout
//  GAP_CYCLES  16        idle cycles (cs=1, mosi=1) between transactions
// PORTS
//  clk_ref      in   1   SPI-domain clock, same clock as engines
//  rst_n        in   1   synchronous reset, active low
//  init_done    in   1   card initialised; no grants before it is high
//  init_cs      in   1   init engine chip select
//  init_mosi    in   1   init engine MOSI
//  wr_req       in   1   user write request (level, held until wr_ack)
//  wr_addr      in   32  user write sector address
//  rd_req       in   1   user read request (level, held until rd_ack)
//  rd_addr      in   32  user read sector address
//  wr_busy      in   1   from sd_write
//  wr_cs        in   1   from sd_write sd_cs
//  wr_mosi      in   1   from sd_write sd_mosi
//  rd_busy      in   1   from sd_read
//  rd_cs        in   1   from sd_read sd_cs
//  rd_mosi      in   1   from sd_read sd_mosi
//  err_clr      in   1   clears timeout_err, leaves ERR
//  wr_start_en  out  1   one-cycle start pulse to sd_write
//  wr_sec_addr  out  32  sector address to sd_write, stable for whole transaction
//  rd_start_en  out  1   one-cycle start pulse to sd_read
//  rd_sec_addr  out  32  sector address to sd_read
//  sd_cs        out  1   muxed SPI chip select (combinational from owner)
//  sd_mosi      out  1   muxed SPI MOSI (combinational from owner)
//  wr_ack       out  1   one-cycle pulse: write transaction finished
//  rd_ack       out  1   one-cycle pulse: read transaction finished
//  ctrl_busy    out  1   high in any state except IDLE
//  timeout_err  out  1   sticky: engine failed BUSY_WAIT or TIMEOUT
// BEHAVIOUR
//  Reset (rst_n=0 at clk_ref edge): state=INIT, owner=INIT, all pulses 0, addrs 0, timeout_err=0,
//   last_grant=RD (so first tie goes to WR), counters 0.
//  Owner mux: INIT->init_cs/init_mosi; WR->wr_cs/wr_mosi; RD->rd_cs/rd_mosi; NONE->cs=1, mosi=1.
//  States:
//   INIT: owner=INIT; init_done=1 -> GAP (owner=NONE).
//   IDLE: owner=NONE. Only wr_req -> grant WR; only rd_req -> grant RD; both -> grant opposite of
//    last_grant. Grant: latch addr into wr/rd_sec_addr, owner=WR/RD, pulse start_en 1 cycle, -> START.
//   START: count up to BUSY_WAIT cycles for selected busy=1 -> RUN (cnt cleared); expiry -> ERR.
//   RUN: cnt++ each cycle; busy=0 -> pulse wr_ack/rd_ack, last_grant=owner, owner=NONE, -> GAP;
//    cnt==TIMEOUT while busy -> ERR.
//   GAP: GAP_CYCLES cycles, owner=NONE -> IDLE.
//   ERR: timeout_err=1, owner=NONE (pins released); err_clr=1 -> timeout_err=0, -> GAP.
//  Start pulse is exactly one cycle (engines edge-detect it); engines see busy ~2-3 cycles later.
//  Grant-to-start latency: start_en high the cycle after IDLE samples a request.
//  Requests dropped before ack are ignored once granted: transaction always completes.
//  ack and a new grant never share a cycle (GAP enforces spacing).
//  init_done falling in any state is ignored (re-init needs rst_n).
//  Counter width: 24 bits, saturating compare; no wrap inside RUN.
// TESTING
//  1 reset, init_done=0 ten cycles -> sd_cs==init_cs, no start pulses; init_done=1 -> IDLE after 16.
//  2 wr_req=1 wr_addr=32'h0000_1234 -> wr_start_en 1 cycle, wr_sec_addr=1234, wr_busy model 600 cycles -> one wr_ack.
//  3 wr_req and rd_req both high in IDLE after reset -> WR first, then RD after 16-cycle gap, alternate.
//  4 start pulse, busy never rises -> after 8 cycles timeout_err=1, sd_cs=1; err_clr -> IDLE.
//  5 TIMEOUT=100, rd_busy held high -> timeout_err at cycle 100, no rd_ack.
//  6 rst_n=0 mid RUN -> next edge outputs at reset values, owner=INIT.

Source files
------------

// File: rtl/sd_spi_arbiter.sv
// rtl/sd_spi_arbiter.sv - SD SPI port arbiter for init, sector-write and sector-read engines
module sd_spi_arbiter #(
    parameter int          BUSY_WAIT  = 8,
    parameter logic [23:0] TIMEOUT    = 24'd2000000,
    parameter int          GAP_CYCLES = 16
) (
    input  logic        clk_ref,
    input  logic        rst_n,
    input  logic        init_done,
    input  logic        init_cs,
    input  logic        init_mosi,
    input  logic        wr_req,
    input  logic [31:0] wr_addr,
    input  logic        rd_req,
    input  logic [31:0] rd_addr,
    input  logic        wr_busy,
    input  logic        wr_cs,
    input  logic        wr_mosi,
    input  logic        rd_busy,
    input  logic        rd_cs,
    input  logic        rd_mosi,
    input  logic        err_clr,
    output logic        wr_start_en,
    output logic [31:0] wr_sec_addr,
    output logic        rd_start_en,
    output logic [31:0] rd_sec_addr,
    output logic        sd_cs,
    output logic        sd_mosi,
    output logic        wr_ack,
    output logic        rd_ack,
    output logic        ctrl_busy,
    output logic        timeout_err
);

    localparam logic [2:0] S_INIT  = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;

    localparam logic [1:0] OWN_INIT = 2'd0;
    localparam logic [1:0] OWN_WR   = 2'd1;
    localparam logic [1:0] OWN_RD   = 2'd2;
    localparam logic [1:0] OWN_NONE = 2'd3;

    // Last cycle index of the start window and of the idle gap.
    localparam logic [23:0] BUSY_LAST = 24'(BUSY_WAIT - 1);
    localparam logic [23:0] GAP_LAST  = 24'(GAP_CYCLES - 1);

    logic [2:0]  state;
    logic [1:0]  owner;
    logic        last_rd;
    logic [23:0] cnt;
    logic        sel_busy;

    // Busy of whichever engine currently holds the grant.
    always_comb begin
        sel_busy = (owner == OWN_RD) ? rd_busy : wr_busy;
    end

    // Pin mux: the owner drives the SPI pins, nobody means idle-high.
    always_comb begin
        sd_cs   = 1'b1;
        sd_mosi = 1'b1;
        case (owner)
            OWN_INIT: begin sd_cs = init_cs; sd_mosi = init_mosi; end
            OWN_WR:   begin sd_cs = wr_cs;   sd_mosi = wr_mosi;   end
            OWN_RD:   begin sd_cs = rd_cs;   sd_mosi = rd_mosi;   end
            default:  begin sd_cs = 1'b1;    sd_mosi = 1'b1;      end
        endcase
    end

    assign ctrl_busy = (state != S_IDLE);

    // Arbitration FSM with start/busy watchdog and inter-transaction gap.
    always_ff @(posedge clk_ref) begin
        if (!rst_n) begin
            state       <= S_INIT;
            owner       <= OWN_INIT;
            last_rd     <= 1'b1;
            cnt         <= 24'd0;
            wr_start_en <= 1'b0;
            rd_start_en <= 1'b0;
            wr_ack      <= 1'b0;
            rd_ack      <= 1'b0;
            wr_sec_addr <= 32'd0;
            rd_sec_addr <= 32'd0;
            timeout_err <= 1'b0;
        end else begin
            wr_start_en <= 1'b0;
            rd_start_en <= 1'b0;
            wr_ack      <= 1'b0;
            rd_ack      <= 1'b0;
            case (state)
                S_INIT: begin
                    if (init_done) begin
                        state <= S_GAP;
                        owner <= OWN_NONE;
                        cnt   <= 24'd0;
                    end
                end
                S_IDLE: begin
                    // On a tie the engine that did not go last wins.
                    if (wr_req && (!rd_req || last_rd)) begin
                        wr_sec_addr <= wr_addr;
                        wr_start_en <= 1'b1;
                        owner       <= OWN_WR;
                        state       <= S_START;
                        cnt         <= 24'd0;
                    end else if (rd_req) begin
                        rd_sec_addr <= rd_addr;
                        rd_start_en <= 1'b1;
                        owner       <= OWN_RD;
                        state       <= S_START;
                        cnt         <= 24'd0;
                    end
                end
                S_START: begin
                    if (sel_busy) begin
                        state <= S_RUN;
                        cnt   <= 24'd0;
                    end else if (cnt >= BUSY_LAST) begin
                        state       <= S_ERR;
                        owner       <= OWN_NONE;
                        timeout_err <= 1'b1;
                    end else begin
                        cnt <= cnt + 24'd1;
                    end
                end
                S_RUN: begin
                    if (!sel_busy) begin
                        wr_ack  <= (owner == OWN_WR);
                        rd_ack  <= (owner == OWN_RD);
                        last_rd <= (owner == OWN_RD);
                        owner   <= OWN_NONE;
                        state   <= S_GAP;
                        cnt     <= 24'd0;
                    end else if (cnt >= TIMEOUT) begin
                        state       <= S_ERR;
                        owner       <= OWN_NONE;
                        timeout_err <= 1'b1;
                    end else begin
                        // Stops at TIMEOUT, so the counter can never wrap here.
                        cnt <= cnt + 24'd1;
                    end
                end
                S_GAP: begin
                    owner <= OWN_NONE;
                    if (cnt >= GAP_LAST) begin
                        state <= S_IDLE;
                        cnt   <= 24'd0;
                    end else begin
                        cnt <= cnt + 24'd1;
                    end
                end
                S_ERR: begin
                    owner <= OWN_NONE;
                    if (err_clr) begin
                        timeout_err <= 1'b0;
                        state       <= S_GAP;
                        cnt         <= 24'd0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    owner <= OWN_NONE;
                    cnt   <= 24'd0;
                end
            endcase
        end
    end

endmodule
